cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
// PURPOSE
//  Miss-handling controller for an L1 cache built around cache_lru. Queues up to MISS_DEPTH
//  outstanding line misses, issues memory reads in order, and on each in-order response sequences
//  the fill: requests a victim way from the LRU (fill_en/fill_set), captures fill_way_idx next cycle,
//  then drives one tag+data array write.
// PARAMETERS
//  NUM_WAYS     4    ways per set (matches cache_lru)
//  NUM_SETS     16   sets (matches cache_lru)
//  TAG_WIDTH    20   line tag width
//  LINE_WIDTH   512  cache line data width
//  MISS_DEPTH   4    outstanding-miss queue entries, power of two >= 2
//  derived: NUM_WAYS_LOG=$clog2(NUM_WAYS), NUM_SETS_LOG=$clog2(NUM_SETS), ADDR_W=TAG_WIDTH+NUM_SETS_LOG
// PORTS
//  clk              in   1             clock
//  rst_n            in   1             asynchronous active-low reset
//  miss_valid       in   1             lookup missed; request line fetch
//  miss_ready       out  1             miss accepted when miss_valid&&miss_ready
//  miss_set         in   NUM_SETS_LOG  set of missing line
//  miss_tag         in   TAG_WIDTH     tag of missing line
//  mem_req_valid    out  1             memory read request
//  mem_req_ready    in   1             memory accepts request
//  mem_req_addr     out  ADDR_W        line address {tag,set}
//  mem_resp_valid   in   1             line data returned (in request order)
//  mem_resp_ready   out  1             controller accepts response
//  mem_resp_data    in   LINE_WIDTH    returned line
//  lru_fill_en      out  1             to cache_lru fill_en
//  lru_fill_set     out  NUM_SETS_LOG  to cache_lru fill_set
//  lru_fill_way_idx in   NUM_WAYS_LOG  from cache_lru fill_way_idx (valid cycle after lru_fill_en)
//  fill_wr_en       out  1             write tag+data arrays
//  fill_wr_set      out  NUM_SETS_LOG  set written
//  fill_wr_way      out  NUM_WAYS_LOG  victim way written
//  fill_wr_tag      out  TAG_WIDTH     tag written
//  fill_wr_data     out  LINE_WIDTH    line written
//  busy             out  1             any queue entry valid
// BEHAVIOUR
//  - Queue: circular, three pointers alloc/issue/head (log2(MISS_DEPTH)+1 bits, wrap via MSB);
//    count = alloc-head. miss_ready = (count != MISS_DEPTH). Alloc on miss accept; entry stores set,tag.
//  - Issue: mem_req_valid = (issue != alloc); addr = {tag,set} of issue entry; issue++ on mem_req_ready.
//    mem_req_valid/addr hold stable until accepted. Combinational from state only, not from miss_valid.
//  - Fill FSM: IDLE -> LRU -> WRITE -> IDLE.
//    IDLE: mem_resp_ready = (head != issue). On response accept: latch data into line register, -> LRU.
//    LRU (1 cycle): lru_fill_en=1, lru_fill_set=head.set. -> WRITE.
//    WRITE (1 cycle): fill_wr_en=1, way=lru_fill_way_idx, set/tag=head entry, data=line register;
//    head++ -> IDLE. Fill throughput: one line per 3 cycles.
//  - mem_resp_valid while head==issue (nothing outstanding) is ignored and never accepted.
//  - Simultaneous alloc and retire (WRITE): count unchanged; full-queue miss stays blocked that cycle
//    (miss_ready registered-count based, no bypass).
//  - Simultaneous alloc and issue on empty queue: no bypass; request leaves one cycle after alloc.
//  - Reset (any time, incl. mid-fill): all pointers 0, FSM IDLE; all outputs 0; miss_ready=1;
//    in-flight memory requests are discarded by the system, not tracked.
//  - busy = (count != 0).
// CONFIGURATION
//  CACHE_MISS_MERGE_EN defined: incoming miss whose {set,tag} equals any valid entry (head..alloc-1)
//    is accepted without allocation (miss_ready=1 even when full); no second memory request or fill.
//  CACHE_MISS_MERGE_EN undefined: every accepted miss allocates; duplicates fetch and fill twice.
// TESTING
//  1 reset: rst_n low mid-WRITE -> all outputs 0, miss_ready=1, busy=0 same cycle (async).
//  2 single miss set=3 tag=0x00ABC, mem_req_ready=1, resp 5 cycles later -> mem_req_addr=0x00ABC3;
//    lru_fill_en 1 cycle after resp; fill_wr_en next cycle, way=lru_fill_way_idx, set=3, tag=0x00ABC.
//  3 five misses back-to-back, mem_req_ready=0 -> 4 accepted, miss_ready=0 on 5th; first WRITE frees
//    an entry, 5th accepted the following cycle.
//  4 mem_req_ready toggling, responses in order -> 4 fills in request order, none lost or duplicated.
//  5 mem_resp_valid=1 with empty queue -> mem_resp_ready=0, no lru_fill_en, no fill_wr_en.
//  6 two misses set=7 tag=0x1 -> with CACHE_MISS_MERGE_EN: 1 request, 1 fill; without: 2 and 2.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// L1 miss controller: in-order miss queue, memory read issue, and LRU-assisted line fill.
// Optional CACHE_MISS_MERGE_EN merges a miss that matches any queued {set,tag} into that entry.
module cache_miss_ctrl #(
  parameter int unsigned NUM_WAYS     = 4,
  parameter int unsigned NUM_SETS     = 16,
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned LINE_WIDTH   = 512,
  parameter int unsigned MISS_DEPTH   = 4,
  localparam int unsigned NUM_WAYS_LOG = $clog2(NUM_WAYS),
  localparam int unsigned NUM_SETS_LOG = $clog2(NUM_SETS),
  localparam int unsigned ADDR_W       = TAG_WIDTH + NUM_SETS_LOG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [NUM_SETS_LOG-1:0] miss_set,
  input  logic [TAG_WIDTH-1:0]    miss_tag,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [LINE_WIDTH-1:0]   mem_resp_data,
  output logic                    lru_fill_en,
  output logic [NUM_SETS_LOG-1:0] lru_fill_set,
  input  logic [NUM_WAYS_LOG-1:0] lru_fill_way_idx,
  output logic                    fill_wr_en,
  output logic [NUM_SETS_LOG-1:0] fill_wr_set,
  output logic [NUM_WAYS_LOG-1:0] fill_wr_way,
  output logic [TAG_WIDTH-1:0]    fill_wr_tag,
  output logic [LINE_WIDTH-1:0]   fill_wr_data,
  output logic                    busy
);

  localparam int unsigned IDX_W = $clog2(MISS_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LRU   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [PTR_W-1:0]        alloc_q, alloc_d, issue_q, issue_d, head_q, head_d;
  logic [PTR_W-1:0]        count;
  logic [1:0]              state_q, state_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [NUM_SETS_LOG-1:0] set_mem [MISS_DEPTH];
  logic [TAG_WIDTH-1:0]    tag_mem [MISS_DEPTH];
  logic [IDX_W-1:0]        head_idx, issue_idx;
  logic                    full, merge_hit, do_alloc, do_issue;

  assign count     = alloc_q - head_q;
  assign full      = (count == PTR_W'(MISS_DEPTH));
  assign busy      = (count != '0);
  assign head_idx  = head_q[IDX_W-1:0];
  assign issue_idx = issue_q[IDX_W-1:0];

`ifdef CACHE_MISS_MERGE_EN
  // Scan only live entries, walking forward from head.
  always_comb begin
    merge_hit = 1'b0;
    for (int unsigned k = 0; k < MISS_DEPTH; k++) begin
      if ((PTR_W'(k) < count) &&
          (set_mem[head_idx + IDX_W'(k)] == miss_set) &&
          (tag_mem[head_idx + IDX_W'(k)] == miss_tag)) begin
        merge_hit = 1'b1;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign miss_ready    = merge_hit | ~full;
  assign do_alloc      = miss_valid & ~full & ~merge_hit;
  assign mem_req_valid = (issue_q != alloc_q);
  assign do_issue      = mem_req_valid & mem_req_ready;
  assign mem_req_addr  = mem_req_valid ? {tag_mem[issue_idx], set_mem[issue_idx]} : '0;
  assign alloc_d       = alloc_q + PTR_W'(do_alloc);
  assign issue_d       = issue_q + PTR_W'(do_issue);

  always_comb begin
    state_d        = state_q;
    line_d         = line_q;
    head_d         = head_q;
    mem_resp_ready = 1'b0;
    lru_fill_en    = 1'b0;
    lru_fill_set   = '0;
    fill_wr_en     = 1'b0;
    fill_wr_set    = '0;
    fill_wr_way    = '0;
    fill_wr_tag    = '0;
    fill_wr_data   = '0;
    unique case (state_q)
      ST_IDLE: begin
        mem_resp_ready = (head_q != issue_q);
        if (mem_resp_valid && mem_resp_ready) begin
          line_d  = mem_resp_data;
          state_d = ST_LRU;
        end
      end
      ST_LRU: begin
        lru_fill_en  = 1'b1;
        lru_fill_set = set_mem[head_idx];
        state_d      = ST_WRITE;
      end
      ST_WRITE: begin
        // Victim way from the LRU is valid the cycle after lru_fill_en.
        fill_wr_en   = 1'b1;
        fill_wr_set  = set_mem[head_idx];
        fill_wr_way  = lru_fill_way_idx;
        fill_wr_tag  = tag_mem[head_idx];
        fill_wr_data = line_q;
        head_d       = head_q + PTR_W'(1);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
      issue_q <= '0;
      head_q  <= '0;
      state_q <= ST_IDLE;
      line_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      issue_q <= issue_d;
      head_q  <= head_d;
      state_q <= state_d;
      line_q  <= line_d;
    end
  end

  // Entry payload needs no reset; every read is qualified by pointer state.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      set_mem[alloc_q[IDX_W-1:0]] <= miss_set;
      tag_mem[alloc_q[IDX_W-1:0]] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl (default 4-way, 16-set, 4-entry build).
module tb_cache_miss_ctrl;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_valid;
  logic          miss_ready;
  logic [3:0]    miss_set;
  logic [19:0]   miss_tag;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [23:0]   mem_req_addr;
  logic          mem_resp_valid;
  logic          mem_resp_ready;
  logic [511:0]  mem_resp_data;
  logic          lru_fill_en;
  logic [3:0]    lru_fill_set;
  logic [1:0]    lru_fill_way_idx;
  logic          fill_wr_en;
  logic [3:0]    fill_wr_set;
  logic [1:0]    fill_wr_way;
  logic [19:0]   fill_wr_tag;
  logic [511:0]  fill_wr_data;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int req_cnt;
  logic [19:0]  fill_tags [$];
  logic [3:0]   fill_sets [$];
  logic [511:0] fill_datas [$];

  cache_miss_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_valid       (miss_valid),
    .miss_ready       (miss_ready),
    .miss_set         (miss_set),
    .miss_tag         (miss_tag),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_ready   (mem_resp_ready),
    .mem_resp_data    (mem_resp_data),
    .lru_fill_en      (lru_fill_en),
    .lru_fill_set     (lru_fill_set),
    .lru_fill_way_idx (lru_fill_way_idx),
    .fill_wr_en       (fill_wr_en),
    .fill_wr_set      (fill_wr_set),
    .fill_wr_way      (fill_wr_way),
    .fill_wr_tag      (fill_wr_tag),
    .fill_wr_data     (fill_wr_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] line_of(input logic [23:0] a);
    return {16{8'h5A, a}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n            = 1'b0;
    miss_valid       = 1'b0;
    miss_set         = '0;
    miss_tag         = '0;
    mem_req_ready    = 1'b0;
    mem_resp_valid   = 1'b0;
    mem_resp_data    = '0;
    lru_fill_way_idx = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Memory responder: returns line_of(addr) in request order; logs every fill.
  task automatic drain(input bit toggle, input int max_cycles);
    logic [23:0] resp_q [$];
    bit accept;
    int cyc = 0;
    req_cnt = 0;
    fill_tags.delete();
    fill_sets.delete();
    fill_datas.delete();
    while ((busy || resp_q.size() != 0) && cyc < max_cycles) begin
      mem_req_ready    = toggle ? cyc[0] : 1'b1;
      mem_resp_valid   = (resp_q.size() != 0);
      mem_resp_data    = (resp_q.size() != 0) ? line_of(resp_q[0]) : '0;
      lru_fill_way_idx = 2'(cyc + 1);
      #1;
      if (mem_req_valid && mem_req_ready) begin
        resp_q.push_back(mem_req_addr);
        req_cnt++;
      end
      accept = mem_resp_valid && mem_resp_ready;
      if (fill_wr_en) begin
        fill_tags.push_back(fill_wr_tag);
        fill_sets.push_back(fill_wr_set);
        fill_datas.push_back(fill_wr_data);
        checks++;
        if (fill_wr_way !== lru_fill_way_idx) begin
          errors++;
          $display("FAIL drain_way: got %0h want %0h", fill_wr_way, lru_fill_way_idx);
        end
      end
      tick();
      if (accept) void'(resp_q.pop_front());
      cyc++;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: busy got %0b want 0 after %0d cycles", busy, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({miss_ready, busy, mem_req_valid, mem_resp_ready, lru_fill_en, fill_wr_en} !== 6'b100000)
    begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 100000", {miss_ready, busy, mem_req_valid,
               mem_resp_ready, lru_fill_en, fill_wr_en});
    end
    apply_reset();
    checks++;
    if (miss_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: miss_ready=%b busy=%b want 1 0", miss_ready, busy);
    end
  endtask

  task automatic test_single();
    apply_reset();
    miss_valid = 1'b1; miss_set = 4'd3; miss_tag = 20'h00ABC; mem_req_ready = 1'b1;
    #1;
    checks++;
    if (miss_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: ready=%b req_valid=%b want 1 0", miss_ready, mem_req_valid);
    end
    tick();
    miss_valid = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 24'h00ABC3) begin
      errors++;
      $display("FAIL single_req: valid=%b addr=%h want 1 00abc3", mem_req_valid, mem_req_addr);
    end
    tick();
    mem_req_ready = 1'b0;
    repeat (4) tick();
    checks++;
    if (mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_wait: req=%b resp_ready=%b busy=%b want 0 1 1", mem_req_valid,
               mem_resp_ready, busy);
    end
    mem_resp_valid = 1'b1; mem_resp_data = line_of(24'h00ABC3);
    #1;
    checks++;
    if (lru_fill_en !== 1'b0) begin
      errors++;
      $display("FAIL single_lru_early: got %b want 0", lru_fill_en);
    end
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0; lru_fill_way_idx = 2'd1;
    #1;
    checks++;
    if (lru_fill_en !== 1'b1 || lru_fill_set !== 4'd3 || fill_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_lru: en=%b set=%0d wr=%b want 1 3 0", lru_fill_en, lru_fill_set,
               fill_wr_en);
    end
    tick();
    checks++;
    if (fill_wr_en !== 1'b1 || fill_wr_way !== 2'd1 || fill_wr_set !== 4'd3 ||
        fill_wr_tag !== 20'h00ABC) begin
      errors++;
      $display("FAIL single_write: en=%b way=%0d set=%0d tag=%h want 1 1 3 00abc", fill_wr_en,
               fill_wr_way, fill_wr_set, fill_wr_tag);
    end
    checks++;
    if (fill_wr_data !== line_of(24'h00ABC3)) begin
      errors++;
      $display("FAIL single_data: got %h want %h", fill_wr_data, line_of(24'h00ABC3));
    end
    tick();
    checks++;
    if (fill_wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: wr=%b busy=%b want 0 0", fill_wr_en, busy);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      miss_valid = 1'b1; miss_set = 4'(i); miss_tag = 20'h100 + 20'(i);
      #1;
      checks++;
      if (miss_ready !== (i < 4)) begin
        errors++;
        $display("FAIL full_ready_%0d: got %b want %b", i, miss_ready, (i < 4));
      end
      if (i < 4) tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = line_of(24'h001000);
    tick();
    mem_resp_valid = 1'b0;
    tick();
    checks++;
    if (fill_wr_en !== 1'b1 || miss_ready !== 1'b0 || fill_wr_tag !== 20'h100) begin
      errors++;
      $display("FAIL full_retire: wr=%b ready=%b tag=%h want 1 0 100", fill_wr_en, miss_ready,
               fill_wr_tag);
    end
    tick();
    checks++;
    if (miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_fifth_accept: got %b want 1", miss_ready);
    end
    tick();
    miss_valid = 1'b0;
    drain(1'b0, 200);
    checks++;
    if (fill_tags.size() != 4) begin
      errors++;
      $display("FAIL full_drain_count: got %0d want 4", fill_tags.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fill_tags[i] !== 20'h101 + 20'(i)) begin
          errors++;
          $display("FAIL full_drain_tag_%0d: got %h want %h", i, fill_tags[i], 20'h101 + 20'(i));
        end
      end
    end
  endtask

  task automatic test_toggle();
    logic [3:0]  sets [4];
    logic [19:0] tags [4];
    sets = '{4'd5, 4'd9, 4'd0, 4'd15};
    tags = '{20'h2000A, 20'hFFFFF, 20'h00001, 20'h12345};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1; miss_set = sets[i]; miss_tag = tags[i];
      tick();
    end
    miss_valid = 1'b0;
    drain(1'b1, 300);
    checks++;
    if (req_cnt != 4 || fill_tags.size() != 4) begin
      errors++;
      $display("FAIL toggle_counts: reqs=%0d fills=%0d want 4 4", req_cnt, fill_tags.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fill_tags[i] !== tags[i] || fill_sets[i] !== sets[i] ||
            fill_datas[i] !== line_of({tags[i], sets[i]})) begin
          errors++;
          $display("FAIL toggle_fill_%0d: tag=%h set=%0d want %h %0d", i, fill_tags[i],
                   fill_sets[i], tags[i], sets[i]);
        end
      end
    end
  endtask

  task automatic test_spurious_resp();
    apply_reset();
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'hDEADBEEF}};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_resp_ready !== 1'b0 || lru_fill_en !== 1'b0 || fill_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL spurious_%0d: resp_ready=%b lru=%b wr=%b want 0 0 0", i, mem_resp_ready,
                 lru_fill_en, fill_wr_en);
      end
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_merge();
    int exp_n;
`ifdef CACHE_MISS_MERGE_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      miss_valid = 1'b1; miss_set = 4'd7; miss_tag = 20'h1;
      #1;
      checks++;
      if (miss_ready !== 1'b1) begin
        errors++;
        $display("FAIL merge_ready_%0d: got %b want 1", i, miss_ready);
      end
      tick();
    end
    miss_valid = 1'b0;
    drain(1'b0, 100);
    checks++;
    if (req_cnt != exp_n || fill_tags.size() != exp_n) begin
      errors++;
      $display("FAIL merge_counts: reqs=%0d fills=%0d want %0d", req_cnt, fill_tags.size(), exp_n);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    miss_valid = 1'b1; miss_set = 4'd2; miss_tag = 20'h55;
    tick();
    miss_set = 4'd4; miss_tag = 20'h66;
    tick();
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = line_of(24'h000552);
    tick();
    mem_resp_valid = 1'b0; lru_fill_way_idx = 2'd3;
    tick();
    checks++;
    if (fill_wr_en !== 1'b1 || mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL midwrite_pre: wr=%b req=%b want 1 1", fill_wr_en, mem_req_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fill_wr_en !== 1'b0 || fill_wr_way !== '0 || fill_wr_set !== '0 || fill_wr_tag !== '0 ||
        fill_wr_data !== '0) begin
      errors++;
      $display("FAIL midwrite_fill: en=%b way=%0d set=%0d tag=%h want all 0", fill_wr_en,
               fill_wr_way, fill_wr_set, fill_wr_tag);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_resp_ready !== 1'b0 ||
        lru_fill_en !== 1'b0 || lru_fill_set !== '0 || miss_ready !== 1'b1 || busy !== 1'b0)
    begin
      errors++;
      $display("FAIL midwrite_ctrl: req=%b addr=%h rr=%b lru=%b ready=%b busy=%b want 0 0 0 0 1 0",
               mem_req_valid, mem_req_addr, mem_resp_ready, lru_fill_en, miss_ready, busy);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_toggle();
    test_spurious_resp();
    test_merge();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
